// File: rtl/bp_pkg.sv
// Shared constants and helpers for the fetch-stage branch predictor.
package bp_pkg;

  localparam int unsigned MODE_BIMODAL = 0;
  localparam int unsigned MODE_GSHARE  = 1;
  localparam int unsigned BP_MAX_CTR_W = 8;

  // Counter value after reset: weakly not taken.
  function automatic logic [BP_MAX_CTR_W-1:0] ctr_reset(input int unsigned w);
    return BP_MAX_CTR_W'((32'd1 << (w - 32'd1)) - 32'd1);
  endfunction

  // Counter value forced on a fresh BTB allocation: weakly taken.
  function automatic logic [BP_MAX_CTR_W-1:0] ctr_alloc(input int unsigned w);
    return BP_MAX_CTR_W'(32'd1 << (w - 32'd1));
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch lookup and EX resolution signals between the pipeline and the predictor.
interface branch_predict_unit_if #(
  parameter int unsigned PC_W   = 12,
  parameter int unsigned HIST_W = 4
);
  logic              fetch_valid;
  logic [PC_W-1:0]   fetch_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic [HIST_W-1:0] pred_ghr;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic [PC_W-1:0]   upd_target;
  logic [HIST_W-1:0] upd_ghr;
  logic              upd_mispredict;

  modport master (
    output fetch_valid, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_ghr, upd_mispredict,
    input  pred_hit, pred_taken, pred_target, pred_ghr
  );

  modport slave (
    input  fetch_valid, fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_ghr, upd_mispredict,
    output pred_hit, pred_taken, pred_target, pred_ghr
  );
endinterface

// File: rtl/bp_sat_counter.sv
// Combinational next value of a saturating up/down counter with load override.
module bp_sat_counter #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  output logic [CTR_W-1:0] ctr_next_c
);

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

  always_comb begin
    ctr_next_c = ctr_i;
    if (load) begin
      ctr_next_c = load_val;
    end else if (inc && (ctr_i != CTR_MAX)) begin
      ctr_next_c = ctr_i + CTR_W'(1);
    end else if (dec && (ctr_i != '0)) begin
      ctr_next_c = ctr_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB plus PHT of saturating counters (bimodal or gshare), with a
// speculative global history that is restored from the EX checkpoint on mispredict.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned HIST_W  = 4,
  parameter int unsigned MODE    = MODE_BIMODAL
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bp
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_RST   = CTR_W'(ctr_reset(CTR_W));
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_alloc(CTR_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } btb_entry_t;

  btb_entry_t        btb_q [ENTRIES];
  btb_entry_t        btb_d [ENTRIES];
  logic [CTR_W-1:0]  pht_q [ENTRIES];
  logic [CTR_W-1:0]  pht_d [ENTRIES];
  logic [HIST_W-1:0] ghr_q, ghr_d;

  logic [IDX_W-1:0]  f_idx, f_pidx, u_idx, u_pidx;
  logic [TAG_W-1:0]  f_tag, u_tag;
  logic              pred_hit_c, pred_taken_c, u_hit, upd_alloc;
  logic [CTR_W-1:0]  pht_next;
  logic              unused_pc_lsbs;

  // pc[1:0] carry no information for word-aligned fetch.
  assign unused_pc_lsbs = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0]};

  assign f_idx  = bp.fetch_pc[IDX_W+1:2];
  assign f_tag  = bp.fetch_pc[PC_W-1:IDX_W+2];
  assign u_idx  = bp.upd_pc[IDX_W+1:2];
  assign u_tag  = bp.upd_pc[PC_W-1:IDX_W+2];
  assign f_pidx = (MODE == MODE_GSHARE) ? (f_idx ^ IDX_W'(ghr_q)) : f_idx;
  assign u_pidx = (MODE == MODE_GSHARE) ? (u_idx ^ IDX_W'(bp.upd_ghr)) : u_idx;

  // Zero-latency lookup on pre-update state.
  always_comb begin
    pred_hit_c     = btb_q[f_idx].valid && (btb_q[f_idx].tag == f_tag);
    pred_taken_c   = pred_hit_c && pht_q[f_pidx][CTR_W-1];
    bp.pred_hit    = pred_hit_c;
    bp.pred_taken  = pred_taken_c;
    bp.pred_target = pred_hit_c ? btb_q[f_idx].target : '0;
    bp.pred_ghr    = ghr_q;
  end

  assign u_hit     = btb_q[u_idx].valid && (btb_q[u_idx].tag == u_tag);
  assign upd_alloc = bp.upd_valid && bp.upd_taken && !u_hit;

  bp_sat_counter #(.CTR_W(CTR_W)) u_pht_ctr (
    .ctr_i      (pht_q[u_pidx]),
    .inc        (bp.upd_taken),
    .dec        (!bp.upd_taken),
    .load       (upd_alloc),
    .load_val   (CTR_ALLOC),
    .ctr_next_c (pht_next)
  );

  // Resolution writes and history maintenance; checkpoint restore beats fetch shift.
  always_comb begin
    btb_d = btb_q;
    pht_d = pht_q;
    ghr_d = ghr_q;
    if (bp.upd_valid) begin
      pht_d[u_pidx] = pht_next;
      if (bp.upd_taken) begin
        btb_d[u_idx] = '{valid: 1'b1, tag: u_tag, target: bp.upd_target};
      end
    end
    if (bp.upd_valid && bp.upd_mispredict) begin
      ghr_d = HIST_W'({bp.upd_ghr, bp.upd_taken});
    end else if (bp.fetch_valid && pred_hit_c) begin
      ghr_d = HIST_W'({ghr_q, pred_taken_c});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
        pht_q[i] <= CTR_RST;
      end
      ghr_q <= '0;
    end else begin
      btb_q <= btb_d;
      pht_q <= pht_d;
      ghr_q <= ghr_d;
    end
  end

endmodule
